mul_arbiter: RTL

Round-robin controller that shares one `multiplier_unsigned` instance among NREQ independent requesters. It accepts one operand pair at a time, launches the multiplier with a single-cycle start, and waits for its valid pulse. It then returns the WIDTH-bit result, or an error if a watchdog timeout expires, to the requester that issued the operation. It sits between the ALU issue ports and the shared multiplier datapath.

---
 rtl/mul_arbiter.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/mul_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | mul_arbiter: round-robin sharing of one multiplier among NREQ ports    |
// | Rev 1.0 - initial release                                              |
// +------------------------------------------------------------------------+
module mul_arbiter #(
  parameter int unsigned WIDTH   = 24,
  parameter int unsigned NREQ    = 4,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [NREQ-1:0]       req_valid_i,
  output logic [NREQ-1:0]       req_ready_o,
  input  logic [NREQ*WIDTH-1:0] req_rs1_i,
  input  logic [NREQ*WIDTH-1:0] req_rs2_i,
  output logic [NREQ-1:0]       resp_valid_o,
  output logic [WIDTH-1:0]      resp_result_o,
  output logic                  resp_err_o,
  output logic                  busy_o,
  output logic [WIDTH-1:0]      mul_rs1_o,
  output logic [WIDTH-1:0]      mul_rs2_o,
  output logic                  mul_start_o,
  input  logic [WIDTH-1:0]      mul_result_i,
  input  logic                  mul_valid_i,
  input  logic                  mul_busy_i
);

  localparam int unsigned C_PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned C_CW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [C_PW-1:0]   ptr_q, ptr_d;
  logic [C_PW-1:0]   owner_q, owner_d;
  logic [C_CW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]  rs1_q, rs1_d;
  logic [WIDTH-1:0]  rs2_q, rs2_d;
  logic [WIDTH-1:0]  res_q, res_d;
  logic              err_q, err_d;
  logic              start_q, start_d;
  logic              busy_q, busy_d;

  logic              grant_found;
  logic [C_PW-1:0]   grant_idx;
  logic              accept;

  // First pending request at or above ptr, wrapping past NREQ-1 back to 0.
  always_comb begin
    int unsigned idx;
    idx         = 0;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = 32'(ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!grant_found && req_valid_i[idx[C_PW-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = idx[C_PW-1:0];
      end
    end
  end

  assign accept = (state_q == S_IDLE) && !mul_busy_i && grant_found;

  always_comb begin
    for (int unsigned i = 0; i < NREQ; i++) begin
      req_ready_o[i]  = accept && (grant_idx == C_PW'(i));
      resp_valid_o[i] = (state_q == S_RESP) && (owner_q == C_PW'(i));
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    res_d   = res_q;
    err_d   = err_q;
    start_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          owner_d = grant_idx;
          ptr_d   = (grant_idx == C_PW'(NREQ - 1)) ? '0 : grant_idx + C_PW'(1);
          rs1_d   = req_rs1_i[grant_idx*WIDTH +: WIDTH];
          rs2_d   = req_rs2_i[grant_idx*WIDTH +: WIDTH];
          start_d = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A completion in the final watchdog cycle still counts as success.
        if (mul_valid_i) begin
          res_d   = mul_result_i;
          err_d   = 1'b0;
          state_d = S_RESP;
        end else if (cnt_q == C_CW'(TIMEOUT - 1)) begin
          res_d   = '0;
          err_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + C_CW'(1);
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      cnt_q   <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      res_q   <= res_d;
      err_q   <= err_d;
      start_q <= start_d;
      busy_q  <= busy_d;
    end
  end

  assign resp_result_o = (state_q == S_RESP) ? res_q : '0;
  assign resp_err_o    = (state_q == S_RESP) && err_q;
  assign busy_o        = busy_q;
  assign mul_rs1_o     = rs1_q;
  assign mul_rs2_o     = rs2_q;
  assign mul_start_o   = start_q;

endmodule
`default_nettype wire
